// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - fetch front end bus: I-cache, predictor, restore and decode ports
interface fetch_queue_unit_if #(
  parameter int WIDTH = 4,
  parameter int DEQ_W = 4
);
  localparam int CW = $clog2(DEQ_W + 1);

  logic [WIDTH*32-1:0] fetch_pcs;
  logic [WIDTH*32-1:0] icache_data;
  logic [WIDTH-1:0]    icache_hit;
  logic                icache_miss_req;
  logic [31:0]         icache_miss_addr;
  logic                icache_refill_done;
  logic [WIDTH-1:0]    bp_taken;
  logic [WIDTH-1:0]    btb_hit;
  logic [WIDTH*32-1:0] btb_target;
  logic                restore_valid;
  logic [31:0]         restore_pc;
  logic [DEQ_W*32-1:0] deq_inst;
  logic [DEQ_W*32-1:0] deq_pc;
  logic [DEQ_W-1:0]    deq_pred_taken;
  logic [DEQ_W*32-1:0] deq_pred_pc;
  logic [CW-1:0]       deq_count;
  logic [CW-1:0]       deq_take;

  modport master (
    output fetch_pcs, icache_miss_req, icache_miss_addr,
    output deq_inst, deq_pc, deq_pred_taken, deq_pred_pc, deq_count,
    input  icache_data, icache_hit, icache_refill_done,
    input  bp_taken, btb_hit, btb_target, restore_valid, restore_pc, deq_take
  );

  modport slave (
    input  fetch_pcs, icache_miss_req, icache_miss_addr,
    input  deq_inst, deq_pc, deq_pred_taken, deq_pred_pc, deq_count,
    output icache_data, icache_hit, icache_refill_done,
    output bp_taken, btb_hit, btb_target, restore_valid, restore_pc, deq_take
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - superscalar fetch group cutter feeding a circular fetch queue
module fetch_queue_unit #(
  parameter int          WIDTH    = 4,
  parameter int          DEQ_W    = 4,
  parameter int          QDEPTH   = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               clock,
  input logic               reset,
  fetch_queue_unit_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(DEQ_W + 1);

  typedef enum logic [1:0] {FETCH, MISS_WAIT, REDIRECT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [OW-1:0]   occ_q;
  logic            miss_req_q, miss_go;
  logic [31:0]     miss_addr_q;

  logic [31:0]     q_inst [QDEPTH];
  logic [31:0]     q_pc   [QDEPTH];
  logic [31:0]     q_ppc  [QDEPTH];
  logic            q_ptk  [QDEPTH];

  logic [31:0]     slot_pc [WIDTH];
  logic [31:0]     ppc     [WIDTH];
  logic [WIDTH-1:0] ptk, redir, cut;
  logic            prev_redir;
  logic [6:0]      op;
  logic [OW-1:0]   lim, free, acc;

  // Slot i is cut by its own miss or by a redirect in the slot before it.
  always_comb begin
    ptk = '0;
    redir = '0;
    cut = '0;
    prev_redir = 1'b0;
    op = '0;
    bus.fetch_pcs = '0;
    for (int i = 0; i < WIDTH; i++) begin
      slot_pc[i] = pc_q + 32'(4 * i);
      bus.fetch_pcs[i*32 +: 32] = slot_pc[i];
      op = bus.icache_data[i*32 +: 7];
      ptk[i] = (op == 7'b1100011 && bus.bp_taken[i]) || op == 7'b1101111 || op == 7'b1100111;
      redir[i] = ptk[i] & bus.btb_hit[i];
      ppc[i] = redir[i] ? bus.btb_target[i*32 +: 32] : slot_pc[i] + 32'd4;
      cut[i] = !bus.icache_hit[i] || prev_redir;
      prev_redir = redir[i];
    end
    lim = OW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cut[i]) lim = OW'(i);
    end
    free = OW'(QDEPTH) - occ_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    acc = '0;
    miss_go = 1'b0;
    case (state_q)
      FETCH: begin
        acc = (lim < free) ? lim : free;
        pc_d = pc_q + 32'({acc, 2'b00});
        for (int i = 0; i < WIDTH; i++) begin
          if (OW'(i + 1) == acc && redir[i]) pc_d = ppc[i];
        end
        if (lim == '0 && free != '0) begin
          state_d = MISS_WAIT;
          miss_go = 1'b1;
        end
      end
      MISS_WAIT: if (bus.icache_refill_done) state_d = FETCH;
      REDIRECT:  state_d = FETCH;
      default:   state_d = FETCH;
    endcase
    if (bus.restore_valid) begin
      state_d = REDIRECT;
      pc_d = bus.restore_pc;
      acc = '0;
      miss_go = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      miss_req_q  <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      miss_req_q <= miss_go;
      if (miss_go) miss_addr_q <= pc_q;
      if (bus.restore_valid) begin
        head_q <= '0;
        tail_q <= '0;
        occ_q  <= '0;
      end else begin
        head_q <= head_q + PW'(bus.deq_take);
        tail_q <= tail_q + PW'(acc);
        occ_q  <= occ_q + acc - OW'(bus.deq_take);
      end
    end
  end

  // Payload storage needs no reset: entries are only visible below deq_count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (OW'(i) < acc) begin
        q_inst[tail_q + PW'(i)] <= bus.icache_data[i*32 +: 32];
        q_pc[tail_q + PW'(i)]   <= slot_pc[i];
        q_ppc[tail_q + PW'(i)]  <= ppc[i];
        q_ptk[tail_q + PW'(i)]  <= ptk[i];
      end
    end
  end

  always_comb begin
    bus.deq_count = (occ_q >= OW'(DEQ_W)) ? CW'(DEQ_W) : CW'(occ_q);
    bus.deq_inst = '0;
    bus.deq_pc = '0;
    bus.deq_pred_pc = '0;
    bus.deq_pred_taken = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      if (CW'(j) < bus.deq_count) begin
        bus.deq_inst[j*32 +: 32]    = q_inst[head_q + PW'(j)];
        bus.deq_pc[j*32 +: 32]      = q_pc[head_q + PW'(j)];
        bus.deq_pred_pc[j*32 +: 32] = q_ppc[head_q + PW'(j)];
        bus.deq_pred_taken[j]       = q_ptk[head_q + PW'(j)];
      end
    end
  end

  assign bus.icache_miss_req  = miss_req_q;
  assign bus.icache_miss_addr = miss_addr_q;

  assert property (@(posedge clock) disable iff (!reset) bus.deq_take <= bus.deq_count);
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed scoreboard bench for fetch_queue_unit
module tb_fetch_queue_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [3:0]  F   = 4'b1111;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ppc;
    logic        pt;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  ent_t sb[$];
  int checks = 0;
  int failures = 0;
  int br_slot = -1;
  logic [31:0] br_tgt = '0;
  logic [31:0] cur_pc = '0;

  fetch_queue_unit_if #(.WIDTH(4), .DEQ_W(4)) bus ();

  fetch_queue_unit #(.WIDTH(4), .DEQ_W(4), .QDEPTH(16), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one cycle, checks, returns at the next falling edge.
  task automatic step(input logic [3:0] hit, input int take, input int exp_a,
                      input logic [31:0] exp_pc, input logic rst_v,
                      input logic [31:0] rpc, input logic refill);
    ent_t e;
    bus.icache_hit = hit;
    bus.deq_take = 3'(take);
    bus.restore_valid = rst_v;
    bus.restore_pc = rpc;
    bus.icache_refill_done = refill;
    for (int i = 0; i < 4; i++) begin
      bus.icache_data[i*32 +: 32] = (i == br_slot) ? BEQ : NOP;
      bus.bp_taken[i] = (i == br_slot);
      bus.btb_hit[i] = (i == br_slot);
      bus.btb_target[i*32 +: 32] = br_tgt;
    end
    for (int j = 0; j < take; j++) begin
      e = sb.pop_front();
      chk($sformatf("deq_pc[%0d]", j), bus.deq_pc[j*32 +: 32], e.pc);
      chk($sformatf("deq_inst[%0d]", j), bus.deq_inst[j*32 +: 32], e.inst);
      chk($sformatf("deq_pred_taken[%0d]", j), 32'(bus.deq_pred_taken[j]), 32'(e.pt));
      chk($sformatf("deq_pred_pc[%0d]", j), bus.deq_pred_pc[j*32 +: 32], e.ppc);
    end
    if (rst_v) sb.delete();
    else begin
      for (int i = 0; i < exp_a; i++) begin
        e.pc = cur_pc + 32'(4 * i);
        e.inst = (i == br_slot) ? BEQ : NOP;
        e.pt = (i == br_slot);
        e.ppc = (i == br_slot) ? br_tgt : e.pc + 32'd4;
        sb.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    chk("fetch_pc0", bus.fetch_pcs[31:0], exp_pc);
    chk("deq_count", 32'(bus.deq_count), (sb.size() > 4) ? 32'd4 : 32'(sb.size()));
    cur_pc = exp_pc;
    @(negedge clock);
  endtask

  initial begin
    bus.icache_data = '0;
    bus.icache_hit = '0;
    bus.icache_refill_done = 1'b0;
    bus.bp_taken = '0;
    bus.btb_hit = '0;
    bus.btb_target = '0;
    bus.restore_valid = 1'b0;
    bus.restore_pc = '0;
    bus.deq_take = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_deq_count", 32'(bus.deq_count), 32'd0);
    chk("rst_miss_req", 32'(bus.icache_miss_req), 32'd0);
    chk("rst_miss_addr", bus.icache_miss_addr, 32'd0);
    chk("rst_pc", bus.fetch_pcs[31:0], 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Fill the queue, then a full cycle must neither enqueue nor miss
    step(F, 0, 4, 32'h10, 0, 0, 0);
    step(F, 0, 4, 32'h20, 0, 0, 0);
    step(F, 0, 4, 32'h30, 0, 0, 0);
    step(F, 0, 4, 32'h40, 0, 0, 0);
    step(4'b0000, 0, 0, 32'h40, 0, 0, 0);
    chk("full_no_miss", 32'(bus.icache_miss_req), 32'd0);

    // Restore at full occupancy with a discarded dequeue, then one bubble
    step(F, 2, 0, 32'h0, 1, 32'h0, 0);
    step(F, 0, 0, 32'h0, 0, 0, 0);

    // Partial hit cuts the group, then a slot-0 miss
    step(F, 0, 4, 32'h10, 0, 0, 0);
    step(F, 0, 4, 32'h20, 0, 0, 0);
    step(4'b0011, 0, 2, 32'h28, 0, 0, 0);
    step(4'b0000, 0, 0, 32'h28, 0, 0, 0);
    chk("miss_req_pulse", 32'(bus.icache_miss_req), 32'd1);
    chk("miss_addr", bus.icache_miss_addr, 32'h28);
    step(F, 0, 0, 32'h28, 0, 0, 0);
    chk("miss_req_drop", 32'(bus.icache_miss_req), 32'd0);
    step(F, 0, 0, 32'h28, 0, 0, 1);
    step(F, 2, 4, 32'h38, 0, 0, 0);

    // Predicted-taken branch in slot 2 redirects and cuts slot 3
    br_slot = 2;
    br_tgt = 32'h100;
    step(F, 0, 3, 32'h100, 0, 0, 0);
    br_slot = -1;

    // Drain through MISS_WAIT so the head pointer wraps past the end
    step(4'b0000, 4, 0, 32'h100, 0, 0, 0);
    chk("miss_addr2", bus.icache_miss_addr, 32'h100);
    step(4'b0000, 4, 0, 32'h100, 0, 0, 0);
    step(4'b0000, 4, 0, 32'h100, 0, 0, 0);
    step(F, 0, 0, 32'h100, 0, 0, 1);
    step(F, 3, 4, 32'h110, 0, 0, 0);
    step(F, 4, 4, 32'h120, 0, 0, 0);

    // Asynchronous reset in the middle of a miss wait
    step(4'b0000, 0, 0, 32'h120, 0, 0, 0);
    chk("miss_addr3", bus.icache_miss_addr, 32'h120);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_deq_count", 32'(bus.deq_count), 32'd0);
    chk("mid_rst_miss_req", 32'(bus.icache_miss_req), 32'd0);
    chk("mid_rst_miss_addr", bus.icache_miss_addr, 32'd0);
    chk("mid_rst_pc", bus.fetch_pcs[31:0], 32'h0);
    sb.delete();
    cur_pc = '0;
    @(negedge clock);
    reset = 1'b1;
    step(F, 0, 4, 32'h10, 0, 0, 0);
    step(F, 4, 4, 32'h20, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
